add_sub_result_acc: RTL
=======================

// Module: add_sub_result_acc
// PURPOSE
//   Downstream consumer of the programmable adder/subtractor. Takes one result beat
//   per valid/ready handshake (unsigned sum + carry, or difference + borrow flag),
//   converts it to a signed value and accumulates N_OPS beats in a saturating register.
//   Then presents the group total on an output valid/ready port.
// PARAMETERS
//   DATA_WD  4  operand width of the adder/subtractor feeding this block
//   ACC_WD   8  signed accumulator/result width; must be >= DATA_WD+2
//   N_OPS    4  beats per accumulation group; must be >= 1
// PORTS
//   i_clk        in   1           clock; all state updates on rising edge
//   i_rst        in   1           reset, synchronous, active-high
//   i_valid      in   1           upstream beat valid
//   o_ready      out  1           block can accept a beat
//   i_mode       in   1           0 = add result, 1 = subtract result
//   i_arith_out  in   DATA_WD+1   adder/subtractor result
//   i_ovr        in   1           subtract borrow (1 when a<b); ignored when i_mode=0
//   i_clear      in   1           synchronous abort/clear of the current group
//   o_valid      out  1           group total valid
//   i_ready      in   1           downstream accepts total
//   o_result     out  ACC_WD      signed group total
//   o_sat        out  1           sticky: saturation occurred in this group
// BEHAVIOUR
//   - Beat accepted when i_valid & o_ready. o_ready = (state==ACCUM) & ~i_rst.
//     Combinational, depends on no input except i_rst.
//   - Sample conversion to DATA_WD+2-bit signed value s:
//     - i_mode=0: s = {1'b0, i_arith_out}. Unsigned, range 0 .. 2^(DATA_WD+1)-2.
//     - i_mode=1: s = {i_ovr, i_ovr, i_arith_out[DATA_WD-1:0]}.
//       This is the low bits minus 2^DATA_WD when a borrow occurred.
//       i_arith_out[DATA_WD] is ignored in this mode.
//   - Accumulation: s is sign-extended to ACC_WD+1 bits and added to acc.
//     - Sum > 2^(ACC_WD-1)-1: acc becomes the max; sum < -2^(ACC_WD-1): acc becomes the min.
//     - Either clamp sets sat. sat stays set until the group ends.
//   - FSM, 2 states:
//     - ACCUM: o_valid=0. On accept, update acc, sat and cnt (0..N_OPS-1).
//       If cnt==N_OPS-1 on that accept: go to EMIT next cycle, with the final
//       saturated acc on o_result and sat on o_sat.
//     - EMIT: o_valid=1, o_ready=0. o_result and o_sat are held stable.
//       i_valid is ignored. When i_ready=1: go to ACCUM; acc, cnt and sat clear to 0.
//   - Latency: total appears in the cycle after the N_OPS-th accept.
//     At least one dead cycle per group, so peak throughput is N_OPS beats per N_OPS+1 cycles.
//   - o_result and o_sat are 0 whenever o_valid=0.
//   - i_clear (any state): next cycle is ACCUM with acc=cnt=sat=0 and o_valid=0.
//     - A beat handshaking in the same cycle is consumed and discarded.
//     - i_clear overrides an EMIT handshake; the total is dropped.
//   - Reset: state=ACCUM, acc=0, cnt=0, sat=0. o_valid=0, o_result=0, o_sat=0.
//     o_ready=0 while i_rst is high and 1 in the first cycle after.
//     Reset mid-group or mid-EMIT discards everything.
//   - Priority: i_rst > i_clear > handshake.
// TESTING  (DATA_WD=4, ACC_WD=8, N_OPS=4 unless stated)
//   1. 4 beats, mode0, arith=5'b10011 (19), i_ready=1
//      -> o_valid 1 cycle after 4th accept, o_result=76, o_sat=0.
//      Next beat accepted one cycle later.
//   2. Beats (0,19), (1,{0,1111},ovr=1), (1,{0,1111},ovr=1), (1,{0,0011},ovr=0)
//      -> o_result=20 (19-1-1+3).
//   3. ACC_WD=6: 4x mode0 arith=30 -> o_result=31, o_sat=1.
//      Then 4x mode1 low=0000, ovr=1 (-16 each) -> o_result=-32, o_sat=1.
//      Next group of 4x +1 -> o_result=4, o_sat=0 (sticky cleared).
//   4. Backpressure: i_ready=0 for 3 cycles in EMIT, with i_valid=1 throughout
//      -> o_result stable, o_ready=0, no beats counted.
//      i_ready=1 -> o_valid falls next cycle and the following beat is accepted.
//   5. 2 beats of 7, i_clear with i_valid=1, then 4 beats of 1
//      -> o_result=4 (the cleared beat is discarded).
//   6. i_rst for 1 cycle during EMIT -> o_valid=0, o_result=0 next cycle,
//      o_ready=1 after reset deasserts, fresh group sums correctly.

Source files
------------

// File: rtl/add_sub_result_acc.sv
// Saturating group accumulator for adder/subtractor result beats.
// Each accepted beat is turned into a signed sample and added into a clamped
// accumulator; after N_OPS beats the group total is offered downstream.
//
// state | meaning
// ------+-------------------------------------------------------------
// ACCUM | accepting beats, o_valid=0, accumulating into acc_q
// EMIT  | group total on o_result/o_sat, o_valid=1, waiting for i_ready
module add_sub_result_acc #(
   parameter int DATA_WD = 4,
   parameter int ACC_WD  = 8,
   parameter int N_OPS   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic               i_mode,
   input  logic [DATA_WD:0]   i_arith_out,
   input  logic               i_ovr,
   input  logic               i_clear,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [ACC_WD-1:0]  o_result,
   output logic               o_sat
);

   localparam int SMP_WD = DATA_WD + 2;
   localparam int CNT_WD = (N_OPS > 1) ? $clog2(N_OPS) : 1;
   localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(N_OPS - 1);
   localparam logic [ACC_WD-1:0] ACC_MAX  = {1'b0, {(ACC_WD-1){1'b1}}};
   localparam logic [ACC_WD-1:0] ACC_MIN  = {1'b1, {(ACC_WD-1){1'b0}}};

   typedef enum logic {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_WD-1:0]   acc_q, acc_d;
   logic [CNT_WD-1:0]   cnt_q, cnt_d;
   logic                sat_q, sat_d;

   logic                accept;
   logic [SMP_WD-1:0]   smp;
   logic [ACC_WD:0]     smp_ext;
   logic [ACC_WD:0]     sum;
   logic                ovf;
   logic [ACC_WD-1:0]   acc_sat;

   assign o_ready = (state_q == ACCUM) & ~i_rst;
   assign accept  = i_valid & o_ready;

   // Convert the beat to a signed sample and do the clamped add.
   // One guard bit above ACC_WD is enough because the sample is never wider than acc.
   always_comb begin
      if (i_mode) begin
         // Borrow turns the low bits into (low - 2^DATA_WD); the carry bit is meaningless here.
         smp = {i_ovr, i_ovr, i_arith_out[DATA_WD-1:0]};
      end else begin
         smp = {1'b0, i_arith_out};
      end
      smp_ext = {{(ACC_WD+1-SMP_WD){smp[SMP_WD-1]}}, smp};
      sum     = {acc_q[ACC_WD-1], acc_q} + smp_ext;
      ovf     = sum[ACC_WD] ^ sum[ACC_WD-1];
      if (!ovf) begin
         acc_sat = sum[ACC_WD-1:0];
      end else if (sum[ACC_WD]) begin
         acc_sat = ACC_MIN;
      end else begin
         acc_sat = ACC_MAX;
      end
   end

   // Next-state logic; clear wins over any handshake in the same cycle.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      if (i_clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         sat_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  acc_d = acc_sat;
                  sat_d = sat_q | ovf;
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     state_d = EMIT;
                  end else begin
                     cnt_d = cnt_q + CNT_WD'(1);
                  end
               end
            end
            EMIT: begin
               if (i_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
               end
            end
            default: begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   // Total is only visible while it is being offered.
   always_comb begin
      o_valid  = (state_q == EMIT);
      o_result = o_valid ? acc_q : '0;
      o_sat    = o_valid & sat_q;
   end

endmodule
